// File: rtl/display_controller.sv
// Alarm-clock display controller: picks what the display shows, collects
// four-digit time/alarm entries and produces one-cycle commit strobes.
module display_controller #(
    parameter int unsigned TIMEOUT_SEC    = 10,
    parameter int unsigned ALARM_VIEW_SEC = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick_1sec,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] cur_hours,
    input  logic [5:0] cur_mins,
    input  logic [3:0] alarm_hours,
    input  logic [5:0] alarm_mins,
    input  logic       alarm_match,
    output logic [3:0] hours,
    output logic [5:0] mins,
    output logic [1:0] display_state,
    output logic [2:0] input_count,
    output logic       flashing,
    output logic       load_time,
    output logic       load_alarm,
    output logic [3:0] new_hours,
    output logic [5:0] new_mins,
    output logic       entry_error
);

    localparam int unsigned TMAX = (TIMEOUT_SEC > ALARM_VIEW_SEC) ? TIMEOUT_SEC : ALARM_VIEW_SEC;
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [1:0] SHOW_TIME  = 2'd0;
    localparam logic [1:0] SHOW_ALARM = 2'd1;
    localparam logic [1:0] ENTRY      = 2'd2;
    localparam logic [1:0] COMMIT     = 2'd3;

    logic [1:0]      state, state_n;
    logic [3:0][3:0] dig, dig_n;
    logic [2:0]      cnt_n;
    logic [TW-1:0]   timer, timer_n;
    logic            target, target_n;
    logic            ring_n, err_n;
    logic            key_eff, is_digit, legal;
    logic [3:0]      ent_hours, hours_n;
    logic [5:0]      ent_mins, mins_n;
    logic [1:0]      ds_n;

    // A key pressed while ringing, or together with alarm_match, only silences
    assign key_eff  = key_valid && !flashing && !alarm_match;
    assign is_digit = (key_code <= 4'd9);

    // Legality of a digit at the position it would occupy
    always_comb begin
        legal = 1'b0;
        case (input_count)
            3'd0:    legal = (key_code <= 4'd1);
            3'd1:    legal = (dig[0] == 4'd1) ? (key_code <= 4'd2) : (key_code != 4'd0);
            3'd2:    legal = (key_code <= 4'd5);
            3'd3:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        dig_n    = dig;
        cnt_n    = input_count;
        timer_n  = timer;
        target_n = target;
        err_n    = 1'b0;
        ring_n   = flashing;
        if (alarm_match)
            ring_n = 1'b1;
        else if (key_valid)
            ring_n = 1'b0;

        case (state)
            SHOW_TIME, SHOW_ALARM: begin
                if (state == SHOW_ALARM && tick_1sec && timer != '1)
                    timer_n = timer + TW'(1);
                if (key_eff) begin
                    case (key_code)
                        4'hA, 4'hB: begin
                            state_n  = ENTRY;
                            target_n = (key_code == 4'hB);
                            dig_n    = '0;
                            cnt_n    = '0;
                            timer_n  = '0;
                        end
                        4'hC: begin
                            state_n = (state == SHOW_TIME) ? SHOW_ALARM : SHOW_TIME;
                            timer_n = '0;
                        end
                        4'hD:    state_n = SHOW_TIME;
                        default: state_n = state;
                    endcase
                end
                if (state_n == SHOW_ALARM && timer_n >= TW'(ALARM_VIEW_SEC))
                    state_n = SHOW_TIME;
            end
            ENTRY: begin
                // Idle timer restarts on any keypress, even a silencing one
                if (key_valid)
                    timer_n = '0;
                else if (tick_1sec && timer != '1)
                    timer_n = timer + TW'(1);
                if (key_eff && is_digit) begin
                    if (legal) begin
                        dig_n[input_count[1:0]] = key_code;
                        cnt_n = input_count + 3'd1;
                        if (input_count == 3'd3)
                            state_n = COMMIT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if ((key_eff && key_code == 4'hD) ||
                    (state_n == ENTRY && timer_n >= TW'(TIMEOUT_SEC))) begin
                    state_n = SHOW_TIME;
                    dig_n   = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = SHOW_TIME;
                dig_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    assign ent_hours = 4'(4'd10 * dig_n[0] + dig_n[1]);
    assign ent_mins  = 6'(6'd10 * 6'(dig_n[2]) + 6'(dig_n[3]));

    // Displayed value follows the state being entered
    always_comb begin
        hours_n = ent_hours;
        mins_n  = ent_mins;
        ds_n    = 2'b10;
        case (state_n)
            SHOW_TIME: begin
                hours_n = cur_hours;
                mins_n  = cur_mins;
                ds_n    = 2'b00;
            end
            SHOW_ALARM: begin
                hours_n = alarm_hours;
                mins_n  = alarm_mins;
                ds_n    = 2'b01;
            end
            default: ds_n = 2'b10;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= SHOW_TIME;
            dig           <= '0;
            timer         <= '0;
            target        <= 1'b0;
            hours         <= '0;
            mins          <= '0;
            display_state <= 2'b00;
            input_count   <= '0;
            flashing      <= 1'b0;
            load_time     <= 1'b0;
            load_alarm    <= 1'b0;
            new_hours     <= '0;
            new_mins      <= '0;
            entry_error   <= 1'b0;
        end else begin
            state         <= state_n;
            dig           <= dig_n;
            timer         <= timer_n;
            target        <= target_n;
            hours         <= hours_n;
            mins          <= mins_n;
            display_state <= ds_n;
            input_count   <= cnt_n;
            flashing      <= ring_n;
            load_time     <= (state_n == COMMIT) && !target_n;
            load_alarm    <= (state_n == COMMIT) && target_n;
            entry_error   <= err_n;
            if (state_n == COMMIT) begin
                new_hours <= ent_hours;
                new_mins  <= ent_mins;
            end
        end
    end

endmodule

// File: tb/tb_display_controller.sv
// Bench for display_controller: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the display rules.
module tb_display_controller;

    localparam int TIMEOUT    = 10;
    localparam int ALARM_VIEW = 5;

    logic       Clock = 1'b0;
    logic       Reset, tick_1sec, key_valid, alarm_match;
    logic [3:0] key_code, cur_hours, alarm_hours;
    logic [5:0] cur_mins, alarm_mins;
    logic [3:0] hours, new_hours;
    logic [5:0] mins, new_mins;
    logic [1:0] display_state;
    logic [2:0] input_count;
    logic       flashing, load_time, load_alarm, entry_error;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    display_controller #(.TIMEOUT_SEC(TIMEOUT), .ALARM_VIEW_SEC(ALARM_VIEW)) dut (
        .Clock(Clock), .Reset(Reset), .tick_1sec(tick_1sec), .key_valid(key_valid),
        .key_code(key_code), .cur_hours(cur_hours), .cur_mins(cur_mins),
        .alarm_hours(alarm_hours), .alarm_mins(alarm_mins), .alarm_match(alarm_match),
        .hours(hours), .mins(mins), .display_state(display_state),
        .input_count(input_count), .flashing(flashing), .load_time(load_time),
        .load_alarm(load_alarm), .new_hours(new_hours), .new_mins(new_mins),
        .entry_error(entry_error)
    );

    logic [28:0] dut_vec, exp_vec;
    assign dut_vec = {hours, mins, display_state, input_count, flashing,
                      load_time, load_alarm, new_hours, new_mins, entry_error};

    // Behavioural model: mode 0 time, 1 alarm view, 2 entry, 3 commit
    int         m_mode, m_idle, m_view;
    int         q[$];
    bit         m_tgt, m_ring;
    logic [3:0] e_nh;
    logic [5:0] e_nm;

    task automatic model_update();
        int  v[4];
        int  hv, mv, k;
        bit  consumed, legal, e_err, e_lt, e_la;
        logic [3:0] e_hours;
        logic [5:0] e_mins;
        logic [1:0] e_ds;
        logic [2:0] e_cnt;
        if (Reset) begin
            m_mode = 0; q.delete(); m_tgt = 0; m_idle = 0; m_view = 0; m_ring = 0;
            e_nh = '0; e_nm = '0; exp_vec = '0;
            return;
        end
        k = int'(key_code);
        consumed = key_valid && (m_ring || alarm_match);
        if (alarm_match) m_ring = 1;
        else if (key_valid) m_ring = 0;
        e_err = 0;
        case (m_mode)
            3: begin m_mode = 0; q.delete(); end
            0, 1: begin
                if (m_mode == 1 && tick_1sec) m_view++;
                if (key_valid && !consumed) begin
                    if (k == 10 || k == 11) begin
                        m_mode = 2; m_tgt = (k == 11); q.delete(); m_idle = 0;
                    end else if (k == 12) begin
                        m_mode = (m_mode == 0) ? 1 : 0; m_view = 0;
                    end else if (k == 13) m_mode = 0;
                end
                if (m_mode == 1 && m_view >= ALARM_VIEW) m_mode = 0;
            end
            default: begin
                if (key_valid) m_idle = 0;
                else if (tick_1sec) m_idle++;
                if (key_valid && !consumed && k <= 9) begin
                    case (q.size())
                        0:       legal = (k <= 1);
                        1:       legal = (q[0] == 1) ? (k <= 2) : (k >= 1);
                        2:       legal = (k <= 5);
                        default: legal = 1;
                    endcase
                    if (legal) begin
                        q.push_back(k);
                        if (q.size() == 4) m_mode = 3;
                    end else e_err = 1;
                end else if (key_valid && !consumed && k == 13) begin
                    m_mode = 0; q.delete();
                end
                if (m_mode == 2 && m_idle >= TIMEOUT) begin m_mode = 0; q.delete(); end
            end
        endcase
        for (int i = 0; i < 4; i++) v[i] = (i < q.size()) ? q[i] : 0;
        hv = 10 * v[0] + v[1];
        mv = 10 * v[2] + v[3];
        case (m_mode)
            0:       begin e_hours = cur_hours;   e_mins = cur_mins;   e_ds = 2'b00; end
            1:       begin e_hours = alarm_hours; e_mins = alarm_mins; e_ds = 2'b01; end
            default: begin e_hours = 4'(hv);      e_mins = 6'(mv);     e_ds = 2'b10; end
        endcase
        e_cnt = (m_mode >= 2) ? 3'(q.size()) : 3'd0;
        e_lt  = (m_mode == 3) && !m_tgt;
        e_la  = (m_mode == 3) && m_tgt;
        if (m_mode == 3) begin e_nh = 4'(hv); e_nm = 6'(mv); end
        exp_vec = {e_hours, e_mins, e_ds, e_cnt, m_ring, e_lt, e_la, e_nh, e_nm, e_err};
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic cycle(input bit rst, input bit tk, input bit kv,
                         input logic [3:0] kc, input bit am);
        Reset = rst; tick_1sec = tk; key_valid = kv; key_code = kc; alarm_match = am;
        cur_hours   = 4'($urandom_range(1, 12));
        cur_mins    = 6'($urandom_range(0, 59));
        alarm_hours = 4'($urandom_range(1, 12));
        alarm_mins  = 6'($urandom_range(0, 59));
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 4'hA, 1);
        cycle(1, 0, 0, 4'h0, 0);
        vectors++;
        if (dut_vec !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        cycle(0, 0, 0, 4'h0, 0);
        vectors++;
        if (display_state !== 2'b00 || hours !== cur_hours || mins !== cur_mins) begin
            miscompares++;
            $display("FAIL reset_show_time: got ds=%b %0d:%0d want ds=00 %0d:%0d",
                     display_state, hours, mins, cur_hours, cur_mins);
        end
    endtask

    task automatic test_time_entry();
        int d[4] = '{1, 0, 4, 5};
        int loads = 0;
        cycle(0, 0, 1, 4'hA, 0);
        vectors++;
        if (display_state !== 2'b10 || input_count !== 3'd0) begin
            miscompares++; $display("FAIL te_enter: got ds=%b cnt=%0d want ds=10 cnt=0", display_state, input_count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 4'(d[i]), 0);
            vectors++;
            if (input_count !== 3'(i + 1)) begin
                miscompares++; $display("FAIL te_count[%0d]: got %0d want %0d", i, input_count, i + 1);
            end
        end
        loads += int'(load_time);
        vectors++;
        if (load_time !== 1'b1 || load_alarm !== 1'b0 || new_hours !== 4'd10 || new_mins !== 6'd45) begin
            miscompares++;
            $display("FAIL te_commit: got lt=%b la=%b %0d:%0d want lt=1 la=0 10:45",
                     load_time, load_alarm, new_hours, new_mins);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 4'h0, 0);
            loads += int'(load_time);
        end
        vectors++;
        if (loads != 1 || display_state !== 2'b00 || input_count !== 3'd0) begin
            miscompares++;
            $display("FAIL te_after: got loads=%0d ds=%b cnt=%0d want loads=1 ds=00 cnt=0",
                     loads, display_state, input_count);
        end
    endtask

    task automatic test_alarm_entry_error();
        int d[3] = '{7, 3, 0};
        cycle(0, 0, 1, 4'hB, 0);
        cycle(0, 0, 1, 4'h0, 0);
        cycle(0, 0, 1, 4'h0, 0);
        vectors++;
        if (entry_error !== 1'b1 || input_count !== 3'd1) begin
            miscompares++; $display("FAIL ae_reject: got err=%b cnt=%0d want err=1 cnt=1", entry_error, input_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 4'(d[i]), 0);
            vectors++;
            if (entry_error !== 1'b0) begin
                miscompares++; $display("FAIL ae_err_pulse[%0d]: got %b want 0", i, entry_error);
            end
        end
        vectors++;
        if (load_alarm !== 1'b1 || load_time !== 1'b0 || new_hours !== 4'd7 || new_mins !== 6'd30) begin
            miscompares++;
            $display("FAIL ae_commit: got la=%b lt=%b %0d:%0d want la=1 lt=0 7:30",
                     load_alarm, load_time, new_hours, new_mins);
        end
        cycle(0, 0, 0, 4'h0, 0);
    endtask

    task automatic test_timeout();
        bit any_load = 0;
        cycle(0, 0, 1, 4'hA, 0);
        cycle(0, 0, 1, 4'h1, 0);
        cycle(0, 0, 1, 4'h2, 0);
        for (int t = 1; t <= TIMEOUT; t++) begin
            cycle(0, 1, 0, 4'h0, 0);
            any_load |= load_time | load_alarm;
            vectors++;
            if (t < TIMEOUT && (display_state !== 2'b10 || input_count !== 3'd2)) begin
                miscompares++;
                $display("FAIL to_hold[%0d]: got ds=%b cnt=%0d want ds=10 cnt=2", t, display_state, input_count);
            end else if (t == TIMEOUT && (display_state !== 2'b00 || input_count !== 3'd0)) begin
                miscompares++;
                $display("FAIL to_abort: got ds=%b cnt=%0d want ds=00 cnt=0", display_state, input_count);
            end
            cycle(0, 0, 0, 4'h0, 0);
            any_load |= load_time | load_alarm;
        end
        vectors++;
        if (any_load) begin
            miscompares++; $display("FAIL to_no_load: got load=1 want 0");
        end
    endtask

    task automatic test_ringing();
        cycle(0, 0, 0, 4'h0, 1);
        vectors++;
        if (flashing !== 1'b1) begin
            miscompares++; $display("FAIL rg_set: got %b want 1", flashing);
        end
        cycle(0, 0, 1, 4'h5, 0);
        vectors++;
        if (flashing !== 1'b0 || display_state !== 2'b00 || input_count !== 3'd0) begin
            miscompares++;
            $display("FAIL rg_clear: got fl=%b ds=%b cnt=%0d want fl=0 ds=00 cnt=0", flashing, display_state, input_count);
        end
        cycle(0, 0, 1, 4'hA, 1);
        vectors++;
        if (flashing !== 1'b1 || display_state !== 2'b00) begin
            miscompares++; $display("FAIL rg_same_cycle: got fl=%b ds=%b want fl=1 ds=00", flashing, display_state);
        end
        cycle(0, 0, 1, 4'hB, 0);
        vectors++;
        if (flashing !== 1'b0 || display_state !== 2'b00) begin
            miscompares++; $display("FAIL rg_consume: got fl=%b ds=%b want fl=0 ds=00", flashing, display_state);
        end
    endtask

    task automatic test_view_and_reset();
        bit any_load = 0;
        cycle(0, 0, 1, 4'hC, 0);
        vectors++;
        if (display_state !== 2'b01 || hours !== alarm_hours || mins !== alarm_mins) begin
            miscompares++;
            $display("FAIL va_show: got ds=%b %0d:%0d want ds=01 %0d:%0d",
                     display_state, hours, mins, alarm_hours, alarm_mins);
        end
        for (int t = 1; t <= ALARM_VIEW; t++) begin
            cycle(0, 1, 0, 4'h0, 0);
            vectors++;
            if (display_state !== ((t < ALARM_VIEW) ? 2'b01 : 2'b00)) begin
                miscompares++; $display("FAIL va_tick[%0d]: got ds=%b", t, display_state);
            end
            cycle(0, 0, 0, 4'h0, 0);
        end
        cycle(0, 0, 1, 4'hA, 0);
        cycle(0, 0, 1, 4'h1, 0);
        cycle(1, 0, 0, 4'h0, 0);
        vectors++;
        if (display_state !== 2'b00 || input_count !== 3'd0 || load_time !== 1'b0 || hours !== 4'd0) begin
            miscompares++;
            $display("FAIL rs_mid_entry: got ds=%b cnt=%0d lt=%b h=%0d want ds=00 cnt=0 lt=0 h=0",
                     display_state, input_count, load_time, hours);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 4'h0, 0);
            any_load |= load_time | load_alarm;
        end
        vectors++;
        if (any_load || input_count !== 3'd0) begin
            miscompares++; $display("FAIL rs_no_load: got load=%b cnt=%0d want 0 0", any_load, input_count);
        end
    endtask

    task automatic test_random();
        int  kp;
        bit  rst, tk, kv, am;
        logic [3:0] kc;
        for (int blk = 0; blk < 15; blk++) begin
            kp = (blk % 3 == 0) ? 30 : 3;
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                tk  = ($urandom_range(0, 3) == 0);
                kv  = ($urandom_range(0, kp - 1) == 0);
                kc  = 4'($urandom_range(0, 15));
                am  = ($urandom_range(0, 79) == 0);
                cycle(rst, tk, kv, kc, am);
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL random[%0d]: got %h want %h", blk * 200 + c, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_time_entry();
        test_alarm_entry_error();
        test_timeout();
        test_ringing();
        test_view_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10: number of idle ticks after which an unfinished entry aborts.
REQ-002 SHALL have parameter ALARM_VIEW_SEC, default 5: number of ticks the alarm time stays on screen.
REQ-003 SHALL have port Clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port tick_1sec, input, 1 bit: one-Clock pulse, once per second.
REQ-006 SHALL have port key_valid, input, 1 bit: one-Clock pulse per keypress.
REQ-007 SHALL have port key_code, input, 4 bits: 0-9 = digit, A = set time, B = set alarm, C = view alarm, D = cancel, E/F = ignored.
REQ-008 SHALL have ports cur_hours (input, 4 bits) and cur_mins (input, 6 bits): current time, hours 1-12, minutes 0-59.
REQ-009 SHALL have ports alarm_hours (input, 4 bits) and alarm_mins (input, 6 bits): stored alarm time.
REQ-010 SHALL have port alarm_match, input, 1 bit: one-Clock pulse when the alarm time is reached.
REQ-011 SHALL have ports hours (output, 4 bits) and mins (output, 6 bits): values to display.
REQ-012 SHALL have port display_state, output, 2 bits: 00 = current, 01 = alarm, 10 = input.
REQ-013 SHALL have port input_count, output, 3 bits: number of digits entered, 0-4.
REQ-014 SHALL have port flashing, output, 1 bit: alarm is ringing.
REQ-015 SHALL have ports load_time and load_alarm, outputs, 1 bit each: one-Clock commit strobes.
REQ-016 SHALL have ports new_hours (output, 4 bits) and new_mins (output, 6 bits): committed value, valid while a load strobe is high.
REQ-017 SHALL have port entry_error, output, 1 bit: one-Clock pulse when a digit is rejected.

Function
REQ-018 SHALL implement the FSM states SHOW_TIME, SHOW_ALARM, ENTRY and COMMIT; all outputs SHALL be registered.
REQ-019 SHOW_TIME: display_state=00, hours/mins=cur_*. Key A enters ENTRY with target time; key B enters ENTRY with target alarm; key C enters SHOW_ALARM. Digits and D are ignored.
REQ-020 SHOW_ALARM: display_state=01, hours/mins=alarm_*. Returns to SHOW_TIME on key C, key D, or after ALARM_VIEW_SEC ticks. Keys A/B behave as in SHOW_TIME.
REQ-021 On entering ENTRY, the digit buffer d0..d3, input_count and the idle counter SHALL be cleared; display_state=10.
REQ-022 In ENTRY, hours SHALL equal 10*d0+d1 and mins SHALL equal 10*d2+d3, with digits not yet entered reading as 0.
REQ-023 Digit legality: d0 in {0,1}; d1 in 0-2 if d0=1, or 1-9 if d0=0; d2 in 0-5; d3 in 0-9.
REQ-024 A legal digit SHALL be stored at index input_count, and input_count SHALL increment.
REQ-025 An illegal digit SHALL pulse entry_error for one cycle and leave the buffer and count unchanged.
REQ-026 When the 4th digit is accepted, the FSM SHALL go to COMMIT, with input_count=4 for exactly one cycle.
REQ-027 In COMMIT, load_time or load_alarm (per target) SHALL be high, new_hours=10*d0+d1 and new_mins=10*d2+d3; on the next edge the FSM SHALL go to SHOW_TIME with input_count=0.
REQ-028 Key D in ENTRY SHALL abort to SHOW_TIME with no load; keys A/B/C/E/F in ENTRY SHALL be ignored.
REQ-029 The idle counter SHALL clear on any key_valid and increment on each tick_1sec; reaching TIMEOUT_SEC SHALL abort as for key D.
REQ-030 Key events in COMMIT SHALL be ignored.
REQ-031 alarm_match SHALL set the ringing flag in any state; flashing SHALL equal ringing.
REQ-032 While ringing, any key_valid SHALL clear ringing and be consumed with no other effect.
REQ-033 If alarm_match and key_valid occur in the same cycle, ringing SHALL be set and the key consumed.
REQ-034 A tick_1sec and a key_valid in the same cycle SHALL leave the idle counter at 0.
REQ-035 Counters SHALL saturate and never wrap.

Reset
REQ-036 Reset SHALL force state=SHOW_TIME, display_state=00, input_count=0, flashing=0, load_time=0, load_alarm=0, entry_error=0, new_hours=0, new_mins=0, buffer and counters cleared, hours/mins=0 until the next edge; Reset mid-ENTRY SHALL discard the entry with no load.

Verification
REQ-037 Reset, key A, then 1,0,4,5 -> input_count 1,2,3,4; exactly one load_time cycle with new_hours=10, new_mins=45; then display_state=00.
REQ-038 Key B, then 0,0 -> entry_error on the second 0 with input_count staying 1; then 7,3,0 -> load_alarm with 7:30.
REQ-039 Key A, digits 1,2, then 10 ticks with no key -> return to SHOW_TIME, no load strobe, input_count=0.
REQ-040 In SHOW_TIME, alarm_match -> flashing=1; key 5 -> flashing=0 and state unchanged; alarm_match and key in the same cycle -> flashing=1.
REQ-041 Key C -> display_state=01 showing alarm_*, back to 00 after 5 ticks; key A, digit 1, Reset -> display_state=00, input_count=0, no load.
